// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD request arbiter.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int LCD_LINE_CHARS = 16;
  localparam logic [LCD_LINE_CHARS*8-1:0] BLANK_LINE = {LCD_LINE_CHARS{8'h20}};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_request_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after pointer, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(pointer) + k) % N);
      if (!valid && req[cand]) begin
        valid    = 1'b1;
        pick_idx = cand;
        pick     = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/lcd_request_arbiter.sv
// Shares one LCD text path between N_REQ requesters: round-robin grant, line latch,
// start pulse, done tracking with timeout, and an enforced idle gap between transfers.
module lcd_request_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LINE_BITS  = 128,
  parameter int MIN_GAP    = 50000,
  parameter int TX_TIMEOUT = 5000000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LINE_BITS-1:0] line1_in,
  input  logic [N_REQ*LINE_BITS-1:0] line2_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       err,
  output logic                       busy,
  output logic                       lcd_send,
  output logic [LINE_BITS-1:0]       lcd_line1,
  output logic [LINE_BITS-1:0]       lcd_line2,
  input  logic                       lcd_done
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = max_int(MIN_GAP, TX_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (MIN_GAP > 0) ? CNT_W'(MIN_GAP - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam arb_state_t AFTER_XFER     = (MIN_GAP > 0) ? GAP : IDLE;

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req      (req),
    .pointer  (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // One counter serves both the transfer timeout and the gap; it is cleared on each entry.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
  assign timeout = (cnt == TO_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      lcd_send  <= 1'b0;
      lcd_line1 <= LINE_BITS'(BLANK_LINE);
      lcd_line2 <= LINE_BITS'(BLANK_LINE);
    end else begin
      done     <= '0;
      err      <= 1'b0;
      lcd_send <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= pick;
            lcd_line1 <= line1_in[32'(pick_idx)*LINE_BITS +: LINE_BITS];
            lcd_line2 <= line2_in[32'(pick_idx)*LINE_BITS +: LINE_BITS];
            lcd_send  <= 1'b1;
            cnt       <= '0;
            ptr       <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (timeout) begin
            done  <= grant;
            err   <= 1'b1;
            grant <= '0;
            cnt   <= '0;
            state <= AFTER_XFER;
          end else begin
            cnt <= cnt_inc;
            if (!lcd_done) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A completion seen in the timeout cycle wins over the timeout.
          if (lcd_done) begin
            done  <= grant;
            grant <= '0;
            cnt   <= '0;
            state <= AFTER_XFER;
          end else if (timeout) begin
            done  <= grant;
            err   <= 1'b1;
            grant <= '0;
            cnt   <= '0;
            state <= AFTER_XFER;
          end else begin
            cnt <= cnt_inc;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_request_arbiter.sv
// Randomized and directed bench for lcd_request_arbiter against a transaction-level model.
module tb_lcd_request_arbiter;

  localparam int N     = 4;
  localparam int LB    = 128;
  localparam int GAPC  = 8;
  localparam int TO    = 100;
  localparam int NEVER = 1 << 30;
  localparam logic [LB-1:0] BLANK = {16{8'h20}};

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*LB-1:0] line1_in = '0;
  logic [N*LB-1:0] line2_in = '0;
  logic [N-1:0]  grant, done;
  logic          err, busy, lcd_send;
  logic [LB-1:0] lcd_line1, lcd_line2;
  logic          lcd_done = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lcd_drop = 3;
  int lcd_rise = 20;
  int m_ptr = 0;
  int m_idle = 0;
  int s_cyc = 0;
  int cur_i = 0;

  lcd_request_arbiter #(
    .N_REQ      (N),
    .LINE_BITS  (LB),
    .MIN_GAP    (GAPC),
    .TX_TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req),
    .line1_in  (line1_in),
    .line2_in  (line2_in),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .lcd_send  (lcd_send),
    .lcd_line1 (lcd_line1),
    .lcd_line2 (lcd_line2),
    .lcd_done  (lcd_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // LCD model: after a start pulse, done level drops lcd_drop cycles later and rises lcd_rise cycles later.
  initial begin : lcd_model
    int sc;
    bit act;
    sc = 0;
    act = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (lcd_send) begin
        sc = cyc;
        act = 1;
        lcd_done = 1'b1;
      end
      if (act) begin
        if (cyc == sc + lcd_drop) lcd_done = 1'b0;
        if (cyc == sc + lcd_rise) begin
          lcd_done = 1'b1;
          act = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Winner = requesting index at the smallest rotational distance from the pointer.
  function automatic int rr_model(input logic [N-1:0] r, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (r[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] v;
    for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_lines(input int i, input logic [LB-1:0] a, input logic [LB-1:0] b);
    line1_in[i*LB +: LB] = a;
    line2_in[i*LB +: LB] = b;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    req = '0;
    tick();
    tick();
    RESET = 1'b0;
    m_ptr = 0;
    m_idle = cyc;
  endtask

  task automatic xfer_start(input string tag);
    int c0, ei, exp_c, n;
    logic [LB-1:0] e1, e2;
    logic [N-1:0] eg;
    c0 = cyc;
    ei = rr_model(req, m_ptr);
    if (ei < 0) ei = 0;
    eg = '0;
    eg[ei] = 1'b1;
    e1 = line1_in[ei*LB +: LB];
    e2 = line2_in[ei*LB +: LB];
    exp_c = ((c0 > m_idle) ? c0 : m_idle) + 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant === '0 && n < TO * 3);
    checks++;
    if (grant !== eg) begin
      errors++;
      $display("FAIL %s grant got %b want %b", tag, grant, eg);
    end
    checks++;
    if (cyc !== exp_c) begin
      errors++;
      $display("FAIL %s grant_cycle got %0d want %0d", tag, cyc, exp_c);
    end
    checks++;
    if (lcd_send !== 1'b1) begin
      errors++;
      $display("FAIL %s lcd_send_at_grant got %b want 1", tag, lcd_send);
    end
    checks++;
    if (lcd_line1 !== e1 || lcd_line2 !== e2) begin
      errors++;
      $display("FAIL %s lines got %h/%h want %h/%h", tag, lcd_line1, lcd_line2, e1, e2);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_at_grant got %b want 1", tag, busy);
    end
    cur_i = ei;
    s_cyc = cyc;
    tick();
    checks++;
    if (lcd_send !== 1'b0) begin
      errors++;
      $display("FAIL %s lcd_send_width got %b want 0", tag, lcd_send);
    end
  endtask

  task automatic xfer_finish(input string tag);
    int n, exp_c;
    logic exp_err;
    logic [N-1:0] eg;
    if (lcd_drop + 1 <= lcd_rise && lcd_rise + 1 <= TO) begin
      exp_c = s_cyc + lcd_rise + 1;
      exp_err = 1'b0;
    end else begin
      exp_c = s_cyc + TO;
      exp_err = 1'b1;
    end
    eg = '0;
    eg[cur_i] = 1'b1;
    n = 0;
    while (done === '0 && n < TO * 3) begin
      tick();
      n++;
    end
    checks++;
    if (done !== eg) begin
      errors++;
      $display("FAIL %s done got %b want %b", tag, done, eg);
    end
    checks++;
    if (cyc !== exp_c) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want %0d", tag, cyc, exp_c);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err got %b want %b", tag, err, exp_err);
    end
    checks++;
    if (grant !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done grant=%b busy=%b want 0000/1", tag, grant, busy);
    end
    m_ptr = (cur_i + 1) % N;
    m_idle = cyc + GAPC;
  endtask

  task automatic test_reset;
    int pulses;
    RESET = 1'b1;
    req = '0;
    tick();
    tick();
    checks++;
    if (grant !== '0 || done !== '0 || err !== 1'b0 || busy !== 1'b0 || lcd_send !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got g=%b d=%b e=%b b=%b s=%b want all 0", grant, done, err, busy, lcd_send);
    end
    checks++;
    if (lcd_line1 !== BLANK || lcd_line2 !== BLANK) begin
      errors++;
      $display("FAIL reset_lines got %h/%h want %h", lcd_line1, lcd_line2, BLANK);
    end
    RESET = 1'b0;
    m_ptr = 0;
    m_idle = cyc;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (lcd_send !== 1'b0 || grant !== '0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL idle_quiet got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_single;
    set_lines(1, "HELLO WORLD     ", "SECOND LINE TEXT");
    lcd_drop = 3;
    lcd_rise = 20;
    req = 4'b0010;
    xfer_start("single");
    xfer_finish("single");
    req = 4'b0001;
    set_lines(0, rnd_line(), rnd_line());
    xfer_start("after_gap");
    req = '0;
    xfer_finish("after_gap");
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_lines(i, rnd_line(), rnd_line());
    lcd_drop = 2;
    lcd_rise = 10;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      xfer_start("rr");
      checks++;
      if (cur_i !== order[k]) begin
        errors++;
        $display("FAIL rr_order step %0d got %0d want %0d", k, cur_i, order[k]);
      end
      xfer_finish("rr");
    end
    req = '0;
  endtask

  task automatic test_timeout;
    req = 4'b0110;
    lcd_drop = NEVER;
    lcd_rise = NEVER;
    xfer_start("timeout_stuck");
    xfer_finish("timeout_stuck");
    lcd_drop = 2;
    lcd_rise = 15;
    xfer_start("timeout_next");
    xfer_finish("timeout_next");
    lcd_drop = 2;
    lcd_rise = TO - 1;
    xfer_start("timeout_tie");
    xfer_finish("timeout_tie");
    lcd_drop = 2;
    lcd_rise = TO;
    xfer_start("timeout_late");
    xfer_finish("timeout_late");
    lcd_drop = 0;
    lcd_rise = 5;
    xfer_start("early_busy");
    xfer_finish("early_busy");
    req = '0;
  endtask

  task automatic test_late_data;
    logic [LB-1:0] old1;
    old1 = "LATCHED LINE ONE";
    set_lines(0, old1, rnd_line());
    lcd_drop = 2;
    lcd_rise = 20;
    req = 4'b0001;
    xfer_start("late_data");
    tick();
    line1_in[0 +: LB] = "CHANGED LINE ONE";
    tick();
    tick();
    checks++;
    if (lcd_line1 !== old1) begin
      errors++;
      $display("FAIL late_data_hold got %h want %h", lcd_line1, old1);
    end
    xfer_finish("late_data");
    xfer_start("late_data_requeue");
    req = '0;
    xfer_finish("late_data_requeue");
  endtask

  task automatic test_drop;
    int grants;
    req = 4'b0100;
    tick();
    tick();
    req = '0;
    grants = 0;
    for (int i = 0; i < GAPC + 6; i++) begin
      tick();
      if (grant !== '0 || lcd_send !== 1'b0) grants++;
    end
    checks++;
    if (grants !== 0) begin
      errors++;
      $display("FAIL dropped_req got %0d grant cycles want 0", grants);
    end
    set_lines(3, rnd_line(), rnd_line());
    lcd_drop = 1;
    lcd_rise = 9;
    req = 4'b1000;
    xfer_start("after_drop");
    req = '0;
    xfer_finish("after_drop");
  endtask

  task automatic test_mid_reset;
    int pulses;
    set_lines(1, rnd_line(), rnd_line());
    lcd_drop = 2;
    lcd_rise = 40;
    req = 4'b0010;
    xfer_start("mid_reset");
    while (cyc < s_cyc + 6) tick();
    RESET = 1'b1;
    tick();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || done !== '0 || lcd_send !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got g=%b b=%b d=%b s=%b want all 0", grant, busy, done, lcd_send);
    end
    checks++;
    if (lcd_line1 !== BLANK || lcd_line2 !== BLANK) begin
      errors++;
      $display("FAIL mid_reset_lines got %h/%h want %h", lcd_line1, lcd_line2, BLANK);
    end
    RESET = 1'b0;
    req = '0;
    m_ptr = 0;
    m_idle = cyc;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done !== '0 || err !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", pulses);
    end
    for (int i = 0; i < N; i++) set_lines(i, rnd_line(), rnd_line());
    lcd_drop = 1;
    lcd_rise = 8;
    req = 4'b1111;
    xfer_start("post_reset");
    checks++;
    if (cur_i !== 0) begin
      errors++;
      $display("FAIL post_reset_pointer got %0d want 0", cur_i);
    end
    req = '0;
    xfer_finish("post_reset");
  endtask

  task automatic test_random;
    logic [N-1:0] nb;
    int d;
    for (int it = 0; it < 30; it++) begin
      nb = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (nb[i] && !req[i]) set_lines(i, rnd_line(), rnd_line());
      req = req | nb;
      d = $urandom_range(0, 6);
      lcd_drop = d;
      lcd_rise = d + 1 + $urandom_range(0, TO + 10);
      xfer_start("random");
      xfer_finish("random");
      if ($urandom_range(0, 1) == 1) req[cur_i] = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_late_data();
    test_drop();
    test_mid_reset();
    test_random();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_request_arbiter.md
Name: lcd_request_arbiter

Overview:
- Shares the single lcd_module text path between N_REQ requesters, such as button handlers, a status monitor and a counter display.
- Grants one requester at a time, round-robin, and latches that requester's two 16-character lines.
- Pulses the LCD start strobe, then tracks the LCD's done level until the transfer completes.
- Enforces a minimum gap between transfers, and reports completion or timeout back to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LINE_BITS, 128, bits per LCD line (16 ASCII chars x 8).
- MIN_GAP, 50000, idle cycles enforced after each transfer (1 ms at 50 MHz); 0 disables the gap.
- TX_TIMEOUT, 5000000, max cycles from lcd_send to completion (100 ms) before the transfer is aborted as an error.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until that requester's done pulse.
- line1_in  in  N_REQ*LINE_BITS  flattened line-1 text; requester i occupies bits [i*LINE_BITS +: LINE_BITS].
- line2_in  in  N_REQ*LINE_BITS  flattened line-2 text; same packing as line1_in.
- grant  out  N_REQ  one-hot, high from issue until completion.
- done  out  N_REQ  1-cycle pulse to the granted requester on completion or timeout.
- err  out  1  1-cycle pulse coincident with done when the transfer timed out.
- busy  out  1  high in every state except IDLE.
- lcd_send  out  1  1-cycle start pulse, connects to lcd_module sendText.
- lcd_line1  out  LINE_BITS  registered line-1 text to the LCD.
- lcd_line2  out  LINE_BITS  registered line-2 text to the LCD.
- lcd_done  in  1  lcd_module sendingDone; high = idle/finished, low = transfer in progress.

Behaviour:
- Reset values:
  - grant, done, err, lcd_send, busy = 0.
  - lcd_line1/lcd_line2 = 16 ASCII spaces (all bytes 8'h20).
  - RR pointer = 0, counters = 0, state = IDLE.
- RESET mid-transfer aborts immediately: no done pulse is issued; the LCD is left to finish on its own.
- State machine:
  - IDLE: if any req bit is high at cycle t, the rr_arbiter picks the first set bit at or after the pointer (wrapping).
    - At t+1: grant[i]=1, lcd_line1/2 load requester i's slices, lcd_send=1 for exactly one cycle, timeout counter cleared, go to WAIT_BUSY.
    - Pointer becomes (i+1) mod N_REQ.
  - WAIT_BUSY: wait for lcd_done=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for lcd_done=1.
    - In that cycle: done[i]=1 for one cycle, grant cleared.
    - Go to GAP, or to IDLE if MIN_GAP=0.
  - Timeout, both WAIT states: the counter increments every cycle from the lcd_send cycle.
    - On reaching TX_TIMEOUT: done[i]=1 and err=1 for one cycle, grant cleared, go to GAP.
  - GAP: count MIN_GAP cycles, then go to IDLE. Requests stay pending meanwhile and no grant is issued.
- Request rules:
  - req is sampled only in IDLE. A request dropped before grant is simply not served.
  - Changes to req or line data after grant are ignored, because the lines are latched at grant.
  - req still high after done is requeued behind the others via the pointer; no requester waits more than N_REQ-1 transfers.
- Simultaneous events:
  - lcd_done low already at the lcd_send cycle: WAIT_BUSY exits on the next cycle.
  - Timeout and lcd_done=1 in the same WAIT_DONE cycle: treat as normal completion, err=0.
- Counters sized $clog2 of MAX(MIN_GAP, TX_TIMEOUT)+1; no wrap, saturate at terminal count.

Decomposition:
- Package lcd_arb_pkg:
  - state enum {IDLE, WAIT_BUSY, WAIT_DONE, GAP}.
  - LCD_LINE_CHARS=16.
  - BLANK_LINE = {16{8'h20}}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req and pointer; outputs one-hot pick, pick index, and valid.
  - Purely combinational. The pointer register lives in the parent.

Test Plan:
- Reset then idle: no req -> grant=0, lcd_send never pulses, lcd_line1 = 16 spaces.
- Single request: req=4'b0010 with line1_in slice 1 = "HELLO WORLD     " -> next cycle grant=4'b0010, lcd_send 1 cycle, lcd_line1="HELLO WORLD     "; LCD model drops lcd_done 3 cycles later and raises it 20 cycles later -> done[1] pulses on the rise, err=0, then MIN_GAP idle cycles before the next grant.
- Round-robin fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0; each lcd_send separated by >= MIN_GAP cycles.
- Timeout: LCD model holds lcd_done=1 forever, TX_TIMEOUT=100 -> done and err pulse together 100 cycles after lcd_send; the next requester is served after the gap.
- Late data change: line1_in altered 2 cycles after grant -> lcd_line1 keeps the latched value until the next grant.
- Mid-transfer reset: RESET asserted in WAIT_DONE -> next cycle grant=0, busy=0, no done pulse, pointer=0, lines reset to spaces.
